// File: rtl/card_shoe_dealer_if.sv
// Card shoe dealer bus.
// Groups the request/seed/shuffle controls and the dealt-card outputs of
// card_shoe_dealer so that a controller and the dealer connect through one port.
//   master : controller side, drives seed/load_seed/req/shuffle, observes card outputs
//   slave  : dealer side, the reverse
// Signals:
//   seed[4:0]       LFSR seed, sampled with load_seed
//   load_seed       load LFSR with {1'b1, seed}
//   req             request one card
//   shuffle         clear the used-card bitmap / abort a draw
//   card_value[4:0] point value of the last dealt card
//   card_index[5:0] deck index 0..51 of the last dealt card
//   card_valid      one-cycle pulse marking a new card
//   busy            dealer is drawing or presenting
//   deck_empty      no undealt cards remain
//   cards_left[5:0] undealt cards, 0..52
interface card_shoe_dealer_if;
  logic [4:0] seed;
  logic       load_seed;
  logic       req;
  logic       shuffle;
  logic [4:0] card_value;
  logic [5:0] card_index;
  logic       card_valid;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  modport master (
    output seed, load_seed, req, shuffle,
    input  card_value, card_index, card_valid, busy, deck_empty, cards_left
  );

  modport slave (
    input  seed, load_seed, req, shuffle,
    output card_value, card_index, card_valid, busy, deck_empty, cards_left
  );
endinterface

// File: rtl/card_shoe_dealer.sv
// Card shoe dealer.
// Deals pseudo-random cards from a single 52-card deck without replacement. A 6-bit
// maximal-length LFSR (x^6+x^5+1) proposes a candidate each DRAW cycle; values 1..52
// map to deck indices 0..51 and a used-card bitmap rejects repeats. Each dealt card is
// presented as a point value with a one-cycle card_valid pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    card_shoe_dealer_if.slave (seed/load_seed/req/shuffle in, card outputs out)
// Parameters:
//   ACE_VALUE     points for rank 0
//   FACE_VALUE    points for ranks 10..12
//   RESHUFFLE_AT  auto-reshuffle once cards_left <= this after a deal; 0 disables
// Optional feature: define DEALER_INFINITE_DECK_EN to draw with replacement (no bitmap,
// cards_left fixed at 52, deck_empty fixed at 0, RESHUFFLE_AT ignored).
module card_shoe_dealer #(
  parameter int unsigned ACE_VALUE    = 11,
  parameter int unsigned FACE_VALUE   = 10,
  parameter int unsigned RESHUFFLE_AT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  card_shoe_dealer_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StDraw, StPresent} state_e;

  localparam logic [5:0] DeckSize = 6'd52;

  state_e     state_q, state_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [5:0] card_index_q, card_index_d;
  logic [4:0] card_value_q, card_value_d;
  logic       card_valid_q, card_valid_d;
  logic       busy_q, busy_d;

  logic [5:0] lfsr_next;
  logic [5:0] cand_idx;
  logic       cand_in_deck;
  logic       hit;
  logic       clear;
  logic       take;
  logic       auto_reshuffle;
  logic [5:0] cards_left;

  assign lfsr_next    = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  assign cand_idx     = lfsr_q - 6'd1;
  // LFSR is never zero, so only the upper bound needs checking.
  assign cand_in_deck = (lfsr_q <= DeckSize);

  // idx % 13 by conditional subtraction, then rank -> points.
  function automatic logic [4:0] point_value(input logic [5:0] idx);
    logic [5:0] rank;
    rank = idx;
    if (rank >= 6'd39)      rank = rank - 6'd39;
    else if (rank >= 6'd26) rank = rank - 6'd26;
    else if (rank >= 6'd13) rank = rank - 6'd13;
    if (rank == 6'd0)       return 5'(ACE_VALUE);
    else if (rank >= 6'd10) return 5'(FACE_VALUE);
    else                    return 5'(rank + 6'd1);
  endfunction

`ifdef DEALER_INFINITE_DECK_EN
  assign hit            = cand_in_deck;
  assign auto_reshuffle = 1'b0;
  assign cards_left     = DeckSize;
`else
  logic [51:0] used_q, used_d;
  logic [5:0]  cards_left_q, cards_left_d;

  assign hit            = cand_in_deck && !used_q[cand_idx];
  // Evaluated in PRESENT, where cards_left_q already reflects the hit.
  assign auto_reshuffle = (RESHUFFLE_AT != 0) && (32'(cards_left_q) <= RESHUFFLE_AT);
  assign cards_left     = cards_left_q;

  always_comb begin
    used_d       = used_q;
    cards_left_d = cards_left_q;
    if (clear) begin
      used_d       = '0;
      cards_left_d = DeckSize;
    end else if (take) begin
      used_d[cand_idx] = 1'b1;
      cards_left_d     = cards_left_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used_q       <= '0;
      cards_left_q <= DeckSize;
    end else begin
      used_q       <= used_d;
      cards_left_q <= cards_left_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    card_index_d = card_index_q;
    card_value_d = card_value_q;
    clear        = 1'b0;
    take         = 1'b0;
    case (state_q)
      StIdle: begin
        // shuffle > load_seed > req; losers are dropped.
        if (bus.shuffle) begin
          clear = 1'b1;
        end else if (bus.load_seed) begin
          lfsr_d = {1'b1, bus.seed};
        end else if (bus.req && (cards_left != 6'd0)) begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        lfsr_d = lfsr_next;
        if (bus.shuffle) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else if (hit) begin
          take         = 1'b1;
          card_index_d = cand_idx;
          card_value_d = point_value(cand_idx);
          state_d      = StPresent;
        end
      end
      StPresent: begin
        // The pulse always completes; any clear lands on the edge leaving PRESENT.
        clear   = bus.shuffle || auto_reshuffle;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    card_valid_d = (state_d == StPresent);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      lfsr_q       <= 6'b000001;
      card_index_q <= '0;
      card_value_q <= '0;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      card_index_q <= card_index_d;
      card_value_q <= card_value_d;
      card_valid_q <= card_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.card_value = card_value_q;
  assign bus.card_index = card_index_q;
  assign bus.card_valid = card_valid_q;
  assign bus.busy       = busy_q;
  assign bus.cards_left = cards_left;
  assign bus.deck_empty = (cards_left == 6'd0);

endmodule
